fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin write-port arbiter that shares one FIFO instance (parameterised depth/width, dual-port RAM core) among N producers. Each cycle it selects at most one requesting producer, drives the FIFO `write` strobe and `inputBus` from that producer, and returns a one-cycle grant. It keeps its own occupancy count, updated by issued writes and consumer reads, so it never overruns the FIFO despite its registered write path. It sits between the producer blocks and the FIFO's write side; the consumer drives FIFO `read` directly and this block only observes it.

## Interface
- `N`, 4, number of producers (2..8)
- `depth`, 4, FIFO address width; capacity = 2**depth entries
- `width`, 8, data word width

- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req`  in  N  per-producer request; bit i held high while producer i has a word pending
- `data_in`  in  N*width  producer words; producer i owns bits [i*width +: width]
- `read`  in  1  consumer pop strobe, same signal driven to the FIFO
- `full`  in  1  FIFO full flag (safety interlock)
- `grant`  out  N  one-hot, registered; bit i high for one cycle = producer i's word is being written
- `write`  out  1  registered FIFO write strobe
- `inputBus`  out  width  registered FIFO write data
- `count`  out  depth+1  arbiter's occupancy count, 0..2**depth

## Operation
- Reset (reset low, asynchronous): `grant`=0, `write`=0, `inputBus`=0, `count`=0, round-robin pointer `last`=N-1 (producer 0 has highest priority first).
- Eligibility at each rising edge: producer i is eligible if `req[i]`=1 and `grant[i]`=0 (a producer whose grant is currently high is masked for that edge, so a single producer gets at most one write every 2 cycles).
- Issue condition: any eligible producer, `count` < 2**depth, and `full`=0.
- Selection: first eligible producer scanning last+1, last+2, ... modulo N; `last` updates to the winner only on issue.
- On issue: `grant` = one-hot(winner), `write`=1, `inputBus` = winner's word. No issue: `grant`=0, `write`=0, `inputBus` holds its previous value.
- Count: count_next = count + issue − (`read` and count≠0). Simultaneous issue and read leaves `count` unchanged. `read` with count=0 is ignored.
- Eligibility uses `count` before the update; a same-edge read does not free a slot until the next edge (conservative).
- `full`=1 blocks issue regardless of `count`; a mismatch between `full` and `count` is never resolved by writing.
- Producer contract: hold `req[i]` and the word stable until the edge that ends the `grant[i]` cycle; at that edge present the next word or drop `req[i]`. Dropping `req` without a grant is legal and loses nothing.

## Timing
- Request-to-write latency: `req` sampled at edge k → `write`/`grant`/`inputBus` valid in cycle k..k+1 → FIFO captures at edge k+1.
- Aggregate throughput: one write per cycle when ≥2 producers request alternately. A lone producer gets one write per 2 cycles.
- `count` reflects an issued write from edge k, one cycle before the FIFO stores it, so overflow is impossible.
- Reset asserted mid-burst: all outputs clear immediately (asynchronous). A grant in flight is aborted and the FIFO sees `write` drop before the next edge. Producers must re-request after reset.
- Fairness: with all N requesting continuously, each producer is granted exactly once every N cycles.

## Test plan
- Reset and idle: reset low then high, req=0 for 5 cycles → grant=0, write=0, inputBus=0, count=0 throughout.
- Single producer: req=4'b0100 held, data_in word2=8'hA5 → grant=4'b0100 on every other cycle, write pulses match, inputBus=8'hA5, count +1 per grant.
- Round-robin fairness: req=4'b1111 continuously, words 8'h10/11/12/13, no reads → grants 0001,0010,0100,1000 repeating on consecutive cycles; count increments each cycle.
- Fill to capacity (depth=4): all req high, no reads → exactly 16 writes, count=16, then write=0. Pulse read once → count=15 at the next edge, then one more write issues and count returns to 16.
- Simultaneous write and read: count=5, req=4'b0001, read=1 on the issue edge → count stays 5 and write=1 the following cycle.
- Reset mid-operation and full interlock: force full=1 with count=3 and req=4'b0011 → no grant. Assert reset while grant=4'b0010 → grant/write clear immediately, count=0, and after release the first grant goes to producer 0.

Source files
------------

// File: rtl/fifo_write_arbiter_if.sv
// Producer/FIFO write-side bundle shared by the arbiter and its environment.
// The master side drives requests, producer words and the FIFO status; the
// slave side (the arbiter) returns grant, write strobe, write data and count.
interface fifo_write_arbiter_if #(
  parameter int N     = 4,
  parameter int depth = 4,
  parameter int width = 8
);
  logic [N-1:0]       req;
  logic [N*width-1:0] data_in;
  logic               read;
  logic               full;
  logic [N-1:0]       grant;
  logic               write;
  logic [width-1:0]   inputBus;
  logic [depth:0]     count;

  modport master (
    output req, data_in, read, full,
    input  grant, write, inputBus, count
  );

  modport slave (
    input  req, data_in, read, full,
    output grant, write, inputBus, count
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin write-port arbiter sharing one FIFO among N producers.
// Registered write path; an internal occupancy count is bumped on the issue
// edge (one cycle ahead of the FIFO storing the word) so the FIFO can never
// be overrun, and consumer reads are only observed.
module fifo_write_arbiter #(
  parameter int N     = 4,
  parameter int depth = 4,
  parameter int width = 8
) (
  input logic                 clk,
  input logic                 reset,   // asynchronous, active-low
  fifo_write_arbiter_if.slave bus
);

  localparam int             PW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [depth:0] CAP      = {1'b1, {depth{1'b0}}};
  localparam logic [PW-1:0]  LAST_RST = PW'(N - 1);

  logic [N-1:0]     grant_q, grant_d;
  logic             write_q, write_d;
  logic [width-1:0] data_q,  data_d;
  logic [depth:0]   count_q, count_d;
  logic [PW-1:0]    last_q,  last_d;

  logic [N-1:0]     eligible;
  logic             found;
  logic [PW-1:0]    winner;
  logic             issue;
  logic             rd_dec;

  // Pick the first eligible producer after the last winner, and decide issue.
  // NOTE: every variable assigned in an always_comb gets a default at the top;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin : select_p
    int            idx;
    logic [PW-1:0] cand;
    // A producer whose grant is high this cycle is masked for this edge.
    eligible = bus.req & ~grant_q;
    found    = 1'b0;
    winner   = last_q;
    idx      = 0;
    cand     = '0;
    for (int k = 1; k <= N; k++) begin
      idx  = (int'(last_q) + k) % N;
      cand = PW'(idx);
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    // The count is taken before this edge's read; freed slots reopen next edge.
    issue  = found && (count_q < CAP) && !bus.full;
    rd_dec = bus.read && (count_q != '0);
  end

  // Next-state for grant, write strobe, write data, pointer and occupancy.
  always_comb begin
    grant_d = '0;
    write_d = 1'b0;
    data_d  = data_q;
    last_d  = last_q;
    count_d = count_q;
    if (issue) begin
      grant_d[winner] = 1'b1;
      write_d         = 1'b1;
      data_d          = bus.data_in[winner*width +: width];
      last_d          = winner;
    end
    unique case ({issue, rd_dec})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset aborts any grant in flight immediately.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q <= '0;
      write_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      last_q  <= LAST_RST;
    end else begin
      grant_q <= grant_d;
      write_q <= write_d;
      data_q  <= data_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.write    = write_q;
  assign bus.inputBus = data_q;
  assign bus.count    = count_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model that applies
// the arbitration rules directly to the sampled inputs at each rising edge.
module tb_fifo_write_arbiter;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int WIDTH = 8;
  localparam int CAP   = 1 << DEPTH;

  logic clk;
  logic reset;

  fifo_write_arbiter_if #(.N(N), .depth(DEPTH), .width(WIDTH)) bus ();

  fifo_write_arbiter #(.N(N), .depth(DEPTH), .width(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  int         m_count;
  int         m_last;
  int         m_gnt;     // index of producer granted this cycle, -1 if none
  logic       m_write;
  logic [7:0] m_bus;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_last  = N - 1;
    m_gnt   = -1;
    m_write = 1'b0;
    m_bus   = '0;
  endtask

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_gnt >= 0) g[m_gnt] = 1'b1;
    return g;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".grant"}, 32'(bus.grant),    32'(exp_grant()));
    check({tag, ".write"}, 32'(bus.write),    32'(m_write));
    check({tag, ".bus"},   32'(bus.inputBus), 32'(m_bus));
    check({tag, ".count"}, 32'(bus.count),    32'(m_count));
  endtask

  // One clock: model the edge from the sampled inputs, then check #1 later.
  task automatic step(input string tag);
    int win;
    int rd;
    @(posedge clk);
    win = -1;
    if (m_count < CAP && !bus.full) begin
      for (int off = 1; off <= N; off++) begin
        int p;
        p = (m_last + off) % N;
        if (win < 0 && bus.req[p] && m_gnt != p) win = p;
      end
    end
    rd = (bus.read && m_count > 0) ? 1 : 0;
    if (win >= 0) begin
      m_gnt   = win;
      m_last  = win;
      m_bus   = bus.data_in[win*WIDTH +: WIDTH];
      m_write = 1'b1;
      m_count = m_count + 1;
    end else begin
      m_gnt   = -1;
      m_write = 1'b0;
    end
    m_count = m_count - rd;
    #1;
    check_all(tag);
  endtask

  task automatic set_word(input int p, input logic [7:0] v);
    bus.data_in[p*WIDTH +: WIDTH] = v;
  endtask

  // Reset pulse between edges; outputs must clear without waiting for a clock.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    bus.req  = '0;
    bus.read = 1'b0;
    bus.full = 1'b0;
    reset    = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int n;
    reset       = 1'b1;
    bus.req     = '0;
    bus.data_in = '0;
    bus.read    = 1'b0;
    bus.full    = 1'b0;
    model_reset();

    // Reset and idle
    pulse_reset("rst");
    for (int i = 0; i < 5; i++) step("idle");

    // Single producer: one write every other cycle
    set_word(2, 8'hA5);
    bus.req = 4'b0100;
    for (int i = 0; i < 8; i++) step("single");
    check("single.count4", 32'(bus.count), 32'd4);

    // Round-robin fairness with all four requesting
    pulse_reset("rst_rr");
    for (int p = 0; p < N; p++) set_word(p, 8'(8'h10 + p));
    bus.req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step("rr");
      check("rr.order", 32'(bus.grant), 32'(1 << (i % N)));
    end

    // Fill to capacity, then free one slot with a single read
    for (int i = 0; i < 12; i++) step("fill");
    check("fill.cap", 32'(bus.count), 32'(CAP));
    step("fill.hold");
    check("fill.nowrite", 32'(bus.write), 32'd0);
    bus.read = 1'b1;
    step("fill.read");
    check("fill.count15", 32'(bus.count), 32'(CAP - 1));
    bus.read = 1'b0;
    step("fill.refill");
    check("fill.refill_wr", 32'(bus.write), 32'd1);
    check("fill.count16", 32'(bus.count), 32'(CAP));
    step("fill.after");

    // Simultaneous write and read at count=5
    pulse_reset("rst_sim");
    set_word(0, 8'h3C);
    bus.req = 4'b0001;
    n = 0;
    while (m_count < 5 && n < 20) begin step("sim.ramp"); n++; end
    check("sim.ramp_bound", 32'(m_count), 32'd5);
    bus.req = '0;
    step("sim.gap");
    bus.req  = 4'b0001;
    bus.read = 1'b1;
    step("sim.rw");
    check("sim.count5", 32'(bus.count), 32'd5);
    check("sim.write", 32'(bus.write), 32'd1);
    bus.read = 1'b0;
    bus.req  = '0;
    step("sim.end");

    // Full interlock with count=3, then reset while producer 1 is granted
    pulse_reset("rst_full");
    set_word(0, 8'h5A);
    set_word(1, 8'hC3);
    bus.req = 4'b0001;
    n = 0;
    while (m_count < 3 && n < 20) begin step("full.ramp"); n++; end
    check("full.ramp_bound", 32'(m_count), 32'd3);
    bus.req  = 4'b0011;
    bus.full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("full.block");
      check("full.nogrant", 32'(bus.grant), 32'd0);
    end
    bus.full = 1'b0;
    n = 0;
    do begin step("full.seek"); n++; end while (m_gnt != 1 && n < 10);
    check("full.seek_bound", 32'(bus.grant), 32'b0010);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("midrst");
    @(negedge clk);
    reset = 1'b1;
    step("midrst.first");
    check("midrst.p0", 32'(bus.grant), 32'b0001);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bus.req     = N'($urandom);
      bus.data_in = (N*WIDTH)'($urandom);
      bus.read    = ($urandom_range(0, 99) < 40);
      bus.full    = ($urandom_range(0, 99) < 10);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
